// File: rtl/memstage_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states
// and the access-legality rule used by the request logic.
package memstage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True when funct3 is defined for this direction and the address is aligned.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/memstage_if.sv
// Single-outstanding request/acknowledge data-memory bus.
interface memstage_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/memstage_ldalign.sv
// Load aligner: picks the addressed byte/half-word lane from a bus word and
// sign- or zero-extends it according to funct3.
module ldalign
  import memstage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_funct3)
      F3_B:    o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_H:    o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_BU:   o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_HU:   o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/memstage.sv
// Memory-access stage: store-data forwarding, lane encoding, request/ack bus
// FSM with pipeline stall, load alignment and the MEM/WB pipeline register.
module memstage
  import memstage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exmem_memr,
  input  logic            exmem_memw,
  input  logic            exmem_regw,
  input  logic            exmem_memtoreg,
  input  logic [4:0]      exmem_rd,
  input  logic [2:0]      exmem_funct3,
  input  logic [XLEN-1:0] exmem_alures,
  input  logic [XLEN-1:0] exmem_rs2data,
  input  logic            wrdatacon,
  input  logic [XLEN-1:0] memwb_wbdata,
  memstage_if.master      dm,
  output logic            mem_stall,
  output logic            mem_fault,
  output logic            memwb_regw,
  output logic            memwb_memtoreg,
  output logic [4:0]      memwb_rd,
  output logic [XLEN-1:0] memwb_ldata,
  output logic [XLEN-1:0] memwb_alures
);

  state_t          r_state, w_next;
  logic            r_req, r_we;
  logic [XLEN-1:0] r_addr, r_wdata, r_ldata;
  logic [3:0]      r_be;

  logic            w_access, w_legal, w_start, w_fault, w_done_ack;
  logic [1:0]      w_off;
  logic [XLEN-1:0] w_sdata, w_wdata_enc, w_ldata;
  logic [3:0]      w_be_enc;

  assign w_off      = exmem_alures[1:0];
  assign w_access   = exmem_memr | exmem_memw;
  assign w_legal    = access_ok(exmem_memw, exmem_funct3, w_off);
  assign w_start    = (r_state == S_IDLE) & w_access & w_legal;
  assign w_fault    = (r_state == S_IDLE) & w_access & ~w_legal;
  assign w_done_ack = (r_state == S_BUSY) & dm.ack;

  // Gated by rst_n so the stall releases the moment reset is applied,
  // even while EX/MEM still presents a memory instruction.
  assign mem_stall = rst_n & (w_start | (r_state == S_BUSY));
  assign mem_fault = rst_n & w_fault;

  assign w_sdata = wrdatacon ? memwb_wbdata : exmem_rs2data;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_wdata_enc = w_sdata;
    w_be_enc    = 4'b1111;
    if (exmem_memw) begin
      case (exmem_funct3[1:0])
        2'b00: begin
          w_wdata_enc = {4{w_sdata[7:0]}};
          w_be_enc    = 4'b0001 << w_off;
        end
        2'b01: begin
          w_wdata_enc = {2{w_sdata[15:0]}};
          w_be_enc    = w_off[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_BUSY;
      S_BUSY:  if (dm.ack)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  ldalign #(.XLEN(XLEN)) u_ldalign (
    .i_rdata  (dm.rdata),
    .i_off    (w_off),
    .i_funct3 (exmem_funct3),
    .o_data   (w_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_ldata <= '0;
    end else begin
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= exmem_memw;
        r_addr  <= {exmem_alures[XLEN-1:2], 2'b00};
        r_wdata <= w_wdata_enc;
        r_be    <= w_be_enc;
      end else if (w_done_ack) begin
        r_req <= 1'b0;
      end
      if (w_done_ack && exmem_memr) r_ldata <= w_ldata;
    end
  end

  // MEM/WB advances whenever the pipeline is not stalled; a fault inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_regw     <= 1'b0;
      memwb_memtoreg <= 1'b0;
      memwb_rd       <= '0;
      memwb_ldata    <= '0;
      memwb_alures   <= '0;
    end else if (!mem_stall) begin
      memwb_regw     <= exmem_regw & ~w_fault;
      memwb_memtoreg <= exmem_memtoreg & ~w_fault;
      memwb_rd       <= w_fault ? 5'd0 : exmem_rd;
      memwb_ldata    <= r_ldata;
      memwb_alures   <= exmem_alures;
    end
  end

  assign dm.req   = r_req;
  assign dm.we    = r_we;
  assign dm.addr  = r_addr;
  assign dm.wdata = r_wdata;
  assign dm.be    = r_be;

endmodule
